// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, wrap/saturate modes and cascade outputs.
// Optional prescaler divider enabled by defining UDCNT_PRESCALE_EN.
module updown_counter_param #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter int RST_VAL  = 0
`ifdef UDCNT_PRESCALE_EN
    ,
    parameter int PRESCALE = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;
    logic             step;
    logic             psc_last;
    logic             at_top;
    logic             at_bot;

`ifdef UDCNT_PRESCALE_EN
    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE-1);

    logic [PSC_W-1:0] psc_q, psc_d;

    assign psc_last = (psc_q == PSC_LAST);

    // Divider only advances while enabled; a load restarts the period.
    always_comb begin
        psc_d = psc_q;
        if (load) begin
            psc_d = '0;
        end else if (en) begin
            psc_d = psc_last ? '0 : psc_q + PSC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end
`else
    assign psc_last = 1'b1;
`endif

    assign step   = en & psc_last;
    assign at_top = (count_q == MAX_W);
    assign at_bot = (count_q == '0);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        sat_d   = sat_q;
        if (load) begin
            count_d = (load_val > MAX_W) ? MAX_W : load_val;
            sat_d   = 1'b0;
        end else if (step) begin
            if (up_dn) begin
                if (!at_top) begin
                    count_d = count_q + ONE_W;
                    sat_d   = 1'b0;
                end else if (sat_mode) begin
                    sat_d   = 1'b1;
                end else begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                    sat_d   = 1'b0;
                end
            end else begin
                if (!at_bot) begin
                    count_d = count_q - ONE_W;
                    sat_d   = 1'b0;
                end else if (sat_mode) begin
                    sat_d   = 1'b1;
                end else begin
                    count_d = MAX_W;
                    wrap_d  = 1'b1;
                    sat_d   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= RST_W;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            sat_q   <= sat_d;
        end
    end

    // Combinational so a cascaded stage can use it as its enable this cycle.
    assign tc   = step & ((up_dn & at_top) | (~up_dn & at_bot));
    assign q    = count_q;
    assign wrap = wrap_q;
    assign sat  = sat_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench for updown_counter_param: directed scenarios then random
// traffic, all compared against an arithmetic reference model.
module tb_updown_counter_param;

  localparam int WIDTH   = 4;
  localparam int MAX_VAL = 9;
  localparam int RST_VAL = 0;
  localparam int MOD     = MAX_VAL + 1;
`ifdef UDCNT_PRESCALE_EN
  localparam int PRE     = 3;
`else
  localparam int PRE     = 1;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             up_dn = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             sat_mode = 1'b0;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             sat;

  int checks = 0;
  int passed = 0;

  // reference model state
  int m_q    = RST_VAL;
  int m_wrap = 0;
  int m_sat  = 0;
  int m_psc  = 0;

  updown_counter_param #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL),
    .RST_VAL (RST_VAL)
`ifdef UDCNT_PRESCALE_EN
    ,
    .PRESCALE(PRE)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .sat_mode (sat_mode),
    .q        (q),
    .tc       (tc),
    .wrap     (wrap),
    .sat      (sat)
  );

  // clock block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int model_tc();
    if (!en) return 0;
    if (m_psc != PRE - 1) return 0;
    if (up_dn && m_q == MAX_VAL) return 1;
    if (!up_dn && m_q == 0) return 1;
    return 0;
  endfunction

  // Behaviour of one rising edge from the rules, in plain integer arithmetic.
  task automatic model_edge();
    int n;
    bit fire;
    if (rst) begin
      m_q = RST_VAL; m_wrap = 0; m_sat = 0; m_psc = 0;
    end else if (load) begin
      m_q = (int'(load_val) > MAX_VAL) ? MAX_VAL : int'(load_val);
      m_wrap = 0; m_sat = 0; m_psc = 0;
    end else if (en) begin
      fire = (m_psc == PRE - 1);
      m_psc = (m_psc + 1) % PRE;
      m_wrap = 0;
      if (fire) begin
        n = m_q + (up_dn ? 1 : -1);
        if (n < 0 || n > MAX_VAL) begin
          if (sat_mode) m_sat = 1;
          else begin
            m_q = (n + MOD) % MOD; m_wrap = 1; m_sat = 0;
          end
        end else begin
          m_q = n; m_sat = 0;
        end
      end
    end else begin
      m_wrap = 0;
    end
  endtask

  // driver task: one clock with the given inputs, checking tc before the edge
  // and the registered outputs just after it
  task automatic drive(input logic r, input logic ld, input logic e, input logic u,
                       input logic sm, input logic [WIDTH-1:0] lv);
    @(negedge clk);
    rst = r; load = ld; en = e; up_dn = u; sat_mode = sm; load_val = lv;
    #1;
    check("tc", {31'd0, tc}, 32'(model_tc()));
    @(posedge clk);
    model_edge();
    #1;
    check("q", {28'd0, q}, 32'(m_q));
    check("wrap", {31'd0, wrap}, 32'(m_wrap));
    check("sat", {31'd0, sat}, 32'(m_sat));
  endtask

  initial begin
    // reset then count up through the wrap
    drive(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 12 * PRE; i++) drive(0, 0, 1, 1, 0, 0);

    // down wrap from 0
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3 * PRE; i++) drive(0, 0, 1, 0, 0, 0);

    // saturate at top, release downward, saturate at bottom
    drive(0, 1, 0, 1, 1, 8);
    for (int i = 0; i < 4 * PRE; i++) drive(0, 0, 1, 1, 1, 0);
    for (int i = 0; i < PRE; i++) drive(0, 0, 1, 0, 1, 0);
    drive(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 2 * PRE; i++) drive(0, 0, 1, 0, 1, 0);
    for (int i = 0; i < 2; i++) drive(0, 0, 0, 0, 1, 0);

    // priority and clamp
    drive(1, 1, 1, 1, 0, 7);
    drive(0, 1, 1, 1, 0, 15);
    drive(0, 1, 0, 1, 0, 5);
    drive(0, 1, 1, 1, 0, 3);

    // hold and direction toggling
    drive(0, 1, 0, 1, 0, 6);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4 * PRE; i++) drive(0, 0, 1, ((i / PRE) % 2 == 0), 0, 0);

    // prescaler period behaviour: freeze mid-period, load restarts the period
    drive(0, 1, 0, 1, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 1, 0, 0);
    drive(0, 1, 1, 1, 0, 2);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 1, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    // final report
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
